// File: rtl/tug_press_gen.sv
// ============================================================================
//  Module   : tug_press_gen
//  Purpose  : Debounced, single-shot left/right press pulses for the tug game.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tug_press_gen #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic freeze,
  output logic L,
  output logic R
);

  localparam int CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PC_LAST = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_REL = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PC  = CW'(PC_LAST);

  typedef enum logic [2:0] {
    LOCK      = 3'd0,
    IDLE      = 3'd1,
    PRESS_CHK = 3'd2,
    HELD      = 3'd3,
    REL_CHK   = 3'd4
  } state_t;

  // bit 0 = left key, bit 1 = right key; active-high "pressed"
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {~key_r_n, ~key_l_n};
      sync2 <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < 2; i++) begin : g_key
      state_t        st;
      logic [CW-1:0] cnt;
      logic          ev;

      // PRESS_CHK counts its entry sample, so it exits one count earlier
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          st  <= LOCK;
          cnt <= '0;
          ev  <= 1'b0;
        end else begin
          ev <= 1'b0;
          case (st)
            LOCK: begin
              if (sync2[i]) begin
                cnt <= '0;
              end else if (cnt == CNT_REL) begin
                st  <= IDLE;
                cnt <= '0;
              end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
              end
            end
            IDLE: begin
              if (sync2[i]) begin
                st  <= PRESS_CHK;
                cnt <= '0;
              end
            end
            PRESS_CHK: begin
              if (!sync2[i]) begin
                st  <= IDLE;
                cnt <= '0;
              end else if (cnt == CNT_PC) begin
                st  <= HELD;
                cnt <= '0;
                ev  <= 1'b1;
              end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
              end
            end
            HELD: begin
              if (!sync2[i]) begin
                st  <= REL_CHK;
                cnt <= '0;
              end
            end
            REL_CHK: begin
              if (sync2[i]) begin
                st  <= HELD;
                cnt <= '0;
              end else if (cnt == CNT_REL) begin
                st  <= IDLE;
                cnt <= '0;
              end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              st  <= LOCK;
              cnt <= '0;
            end
          endcase
        end
      end

      assign evt[i] = ev;
    end
  endgenerate

  // Simultaneous presses cancel each other; freeze swallows any event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      L <= 1'b0;
      R <= 1'b0;
    end else begin
      L <= evt[0] & ~evt[1] & ~freeze;
      R <= evt[1] & ~evt[0] & ~freeze;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tug_press_gen.sv
// ============================================================================
//  Module   : tb_tug_press_gen
//  Purpose  : Self-checking bench for tug_press_gen (DEBOUNCE_CYCLES = 4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tug_press_gen;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset;
  logic key_l_n;
  logic key_r_n;
  logic freeze;
  logic L;
  logic R;

  tug_press_gen #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_l_n (key_l_n),
    .key_r_n (key_r_n),
    .freeze  (freeze),
    .L       (L),
    .R       (R)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int lcnt       = 0;
  int rcnt       = 0;
  int last_l     = -1;
  int k_edge     = 0;

  // Behavioural model: run lengths of synchronized samples plus an "armed" flag
  bit s1 [2];
  bit s2 [2];
  int prun [2];
  int rrun [2];
  bit armed [2];
  bit from_rst [2];
  bit evq [2];
  bit acc [2];
  bit raw [2];
  bit samp;
  bit exp_l;
  bit exp_r;

  task automatic chk(input string nm, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    raw[0] = !key_l_n;
    raw[1] = !key_r_n;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        s1[i] = 0; s2[i] = 0; prun[i] = 0; rrun[i] = 0;
        armed[i] = 0; from_rst[i] = 1; evq[i] = 0;
      end
      exp_l = 0;
      exp_r = 0;
    end else begin
      exp_l = evq[0] && !evq[1] && !freeze;
      exp_r = evq[1] && !evq[0] && !freeze;
      for (int i = 0; i < 2; i++) begin
        samp  = s2[i];
        s2[i] = s1[i];
        s1[i] = raw[i];
        if (samp) begin
          if (prun[i] < 1000) prun[i]++;
          rrun[i] = 0;
        end else begin
          if (rrun[i] < 1000) rrun[i]++;
          prun[i] = 0;
        end
        acc[i] = armed[i] && samp && (prun[i] == DEB);
        if (acc[i]) begin
          armed[i]    = 0;
          from_rst[i] = 0;
        end else if (!armed[i] && !samp && rrun[i] >= (from_rst[i] ? DEB : DEB + 1)) begin
          armed[i] = 1;
        end
        evq[i] = acc[i];
      end
    end
    #1;
    chk("L_vs_model", int'(L), int'(exp_l));
    chk("R_vs_model", int'(R), int'(exp_r));
    if (L) begin
      lcnt++;
      last_l = cyc;
    end
    if (R) rcnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    lcnt   = 0;
    rcnt   = 0;
    last_l = -1;
  endtask

  initial begin
    reset   = 1'b0;
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    freeze  = 1'b0;
    cycles(3);
    chk("reset_L", int'(L), 0);
    chk("reset_R", int'(R), 0);
    reset = 1'b1;

    // Basic left press held 20 cycles
    cycles(6);
    clear_counts();
    key_l_n = 1'b0; k_edge = cyc + 1;
    cycles(20);
    key_l_n = 1'b1;
    chk("basic_l_count", lcnt, 1);
    chk("basic_l_edge", last_l, k_edge + 6);
    chk("basic_r_count", rcnt, 0);
    cycles(10);

    // Short right press is rejected
    clear_counts();
    key_r_n = 1'b0;
    cycles(3);
    key_r_n = 1'b1;
    cycles(10);
    chk("short_r_count", rcnt, 0);

    // Simultaneous presses cancel, then a single left press
    clear_counts();
    key_l_n = 1'b0; key_r_n = 1'b0;
    cycles(10);
    key_l_n = 1'b1; key_r_n = 1'b1;
    cycles(6);
    chk("both_l_count", lcnt, 0);
    chk("both_r_count", rcnt, 0);
    clear_counts();
    key_l_n = 1'b0; k_edge = cyc + 1;
    cycles(10);
    key_l_n = 1'b1;
    chk("after_both_l_count", lcnt, 1);
    chk("after_both_l_edge", last_l, k_edge + 6);
    cycles(10);

    // Press during freeze, held past freeze falling
    clear_counts();
    freeze = 1'b1; key_l_n = 1'b0;
    cycles(10);
    freeze = 1'b0;
    cycles(5);
    key_l_n = 1'b1;
    cycles(6);
    chk("freeze_l_count", lcnt, 0);
    key_l_n = 1'b0; k_edge = cyc + 1;
    cycles(10);
    key_l_n = 1'b1;
    chk("post_freeze_l_count", lcnt, 1);
    chk("post_freeze_l_edge", last_l, k_edge + 6);
    cycles(10);

    // Key held through reset release
    clear_counts();
    key_l_n = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(10);
    chk("held_reset_l_count", lcnt, 0);
    key_l_n = 1'b1;
    cycles(6);
    key_l_n = 1'b0; k_edge = cyc + 1;
    cycles(10);
    key_l_n = 1'b1;
    chk("post_reset_l_count", lcnt, 1);
    chk("post_reset_l_edge", last_l, k_edge + 6);
    cycles(10);

    // Bounce: low 2, high 1, low 8
    clear_counts();
    key_l_n = 1'b0;
    cycles(2);
    key_l_n = 1'b1;
    cycles(1);
    key_l_n = 1'b0; k_edge = cyc + 1;
    cycles(8);
    key_l_n = 1'b1;
    chk("bounce_l_count", lcnt, 1);
    chk("bounce_l_edge", last_l, k_edge + 6);
    cycles(10);

    // Reset mid-debounce aborts the press
    clear_counts();
    key_l_n = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(2);
    key_l_n = 1'b1;
    reset = 1'b1;
    cycles(10);
    chk("abort_debounce_l_count", lcnt, 0);

    // Reset just before the pulse would appear
    key_l_n = 1'b0; k_edge = cyc + 1;
    cycles(6);
    reset = 1'b0;
    cycles(2);
    key_l_n = 1'b1;
    reset = 1'b1;
    cycles(10);
    chk("abort_pulse_l_count", lcnt, 0);
    chk("abort_pulse_r_count", rcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
